// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DIV_WIDTH_DEFAULT = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/addsub_unit.sv
// Combinational W-bit adder/subtractor; sub=1 computes a + ~b + 1 and cout=1 means no borrow.
module addsub_unit
  import div_pkg::*;
#(
  parameter int W = DIV_WIDTH_DEFAULT + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock using addsub_unit as the trial subtractor.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             no_borrow;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign r_shift = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};

  addsub_unit #(.W(WIDTH + 1)) u_addsub (
    .a    (r_shift),
    .b    ({1'b0, div_q}),
    .sub  (1'b1),
    .sum  (trial),
    .cout (no_borrow)
  );

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    q_d         = q_q;
    r_d         = r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            div_d   = divisor;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        q_d   = {q_q[WIDTH-2:0], no_borrow};
        r_d   = no_borrow ? trial : r_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quotient_d  = q_d;
          remainder_d = r_d[WIDTH-1:0];
          cnt_d       = '0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      q_q         <= q_d;
      r_q         <= r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench: directed cases, randomized busy-start rejection and an exhaustive sweep vs. plain arithmetic.
module tb_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // Called #1 after a rising edge in an IDLE cycle; returns #1 after the edge that leaves DONE.
  // A second start (a2/b2) is pulsed in cycle t+ign when ign>0; it must have no effect.
  task automatic run_div(input int a, input int b, input int ign, input int a2, input int b2);
    int  k, lat, dc0, eq, er, ez;
    bit  seen;
    ref_div(a, b, eq, er, ez);
    lat = (b == 0) ? 1 : W + 1;
    dc0 = done_cnt;
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    #1;
    k    = 1;
    seen = 1'b0;
    while (!seen && k <= 20) begin
      start    = (k == ign);
      dividend = (k == ign) ? W'(a2) : W'($urandom);
      divisor  = (k == ign) ? W'(b2) : W'($urandom);
      @(negedge clk);
      check("busy_run", int'(busy), 1);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    check("latency", k, lat);
    check("quotient", int'(quotient), eq);
    check("remainder", int'(remainder), er);
    check("div_by_zero", int'(div_by_zero), ez);
    @(posedge clk);
    #1;
    check("busy_idle", int'(busy), 0);
    check("done_once", done_cnt - dc0, 1);
  endtask

  initial begin
    int dc0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_div(13, 3, 0, 0, 0);
    run_div(15, 1, 0, 0, 0);
    run_div(5, 7, 0, 0, 0);
    run_div(0, 9, 0, 0, 0);
    run_div(15, 15, 0, 0, 0);
    run_div(9, 0, 0, 0, 0);
    run_div(8, 2, 0, 0, 0);
    run_div(12, 5, 2, 7, 7);

    // Abort mid-run: rst high during cycle t+3.
    dc0      = done_cnt;
    start    = 1'b1;
    dividend = W'(14);
    divisor  = W'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_q", int'(quotient), 0);
    check("abort_r", int'(remainder), 0);
    check("abort_dbz", int'(div_by_zero), 0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - dc0, 0);
    run_div(14, 3, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      run_div(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(1, (1 << W) - 1)),
              int'($urandom_range(1, W + 1)),
              int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
    end

    dc0 = done_cnt;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        run_div(a, b, 0, 0, 0);
      end
    end
    check("sweep_done_count", done_cnt - dc0, 1 << (2 * W));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
Sequential unsigned restoring divider that consumes the team's add/subtract datapath in subtract mode, one quotient bit per clock. It accepts a dividend/divisor pair on a start pulse and returns quotient and remainder after a fixed latency. It sits directly downstream of the add/sub unit, reusing it as its trial-subtract engine inside a small FSM.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (minimum 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend, sampled with start
divisor  input  WIDTH  unsigned divisor, sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  result quotient, held until next accepted start
remainder  output  WIDTH  result remainder, held until next accepted start
div_by_zero  output  1  set with done when divisor==0; held like results

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state registered on rising clk.
- Reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with divisor!=0 captures D=divisor, Q=dividend, R=0 (WIDTH+1 bits), cnt=0, clears div_by_zero, and moves to RUN.
  - start=1 with divisor==0 sets quotient=all ones, remainder=dividend, div_by_zero=1, and moves to DONE.
  - start=0: stay in IDLE.
- RUN, one iteration per cycle:
  - Shift: Rs={R[WIDTH-1:0],Q[WIDTH-1]}, Qs={Q[WIDTH-2:0],0}.
  - Trial: T=Rs-{0,D}, computed by the add/sub sub-module in subtract mode (cin=1, b inverted, width WIDTH+1). Carry-out=1 means no borrow.
  - No borrow: R=T, Q=Qs|1. Borrow: R=Rs, Q=Qs (restore).
  - cnt increments. After the iteration with cnt==WIDTH-1, quotient=Q and remainder=R[WIDTH-1:0] (both from that iteration), then move to DONE.
- DONE: done=1 for exactly one cycle, then unconditional move to IDLE. start is ignored in DONE.
- Latency: start accepted in cycle t gives done=1 in cycle t+WIDTH+1 (t+5 for WIDTH=4). On the divide-by-zero path, done=1 in cycle t+1.
- start while busy is ignored entirely. Operands, results and flag are unaffected.
- dividend/divisor are don't-care except in the start-acceptance cycle.
- Back-to-back: earliest next accepted start is the cycle after done (IDLE). Throughput is one result per WIDTH+2 cycles.
- Invariants at done (divisor!=0): dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, RUN, DONE}
  - DIV_WIDTH_DEFAULT=4
  - counter width function clog2(WIDTH)
- One sub-module, addsub_unit (parameter W, default WIDTH+1):
  - inputs a, b, sub
  - outputs sum = sub ? a+~b+1 : a+b, and cout
  - purely combinational; the divider ties sub=1.
- FSM, counter and shift registers stay in restoring_divider.

Test Plan:
- Nominal: dividend=13, divisor=3, start at t -> done pulse at t+5 only; quotient=4, remainder=1, div_by_zero=0; busy high t+1..t+5.
- Edge values: 15/1 -> q=15, r=0. 5/7 -> q=0, r=5. 0/9 -> q=0, r=0. 15/15 -> q=1, r=0.
- Divide-by-zero: dividend=9, divisor=0 -> done at t+1; quotient=4'hF, remainder=9, div_by_zero=1. A following 8/2 -> q=4, r=0, div_by_zero=0.
- Start while busy: start 12/5, then pulse start with 7/7 at t+2 -> second request ignored; result q=2, r=2; exactly one done pulse.
- Reset mid-run: start 14/3, assert rst at t+3 -> next cycle busy=0, all outputs 0, no done pulse. New start 14/3 then gives q=4, r=2 at expected latency.
- Exhaustive: all 256 dividend/divisor pairs back-to-back, start issued on the first IDLE cycle after each done. Check q=a/b, r=a%b (zero-divisor rule for b=0) and done count == 256.
